bcd_stopwatch_ctrl: RTL and testbench
=====================================

Name: bcd_stopwatch_ctrl

Overview:
- Run/pause/clear controller for a two-digit BCD counter on the DE2-115 board, driven by the 50 MHz board clock.
- Replaces divided-clock timing with an internal prescaler that issues single-cycle tick enables; all logic stays in the clk domain.
- Sequences the counter through IDLE/RUN/PAUSE from button pulses, supports up/down counting with a programmable wrap limit, and drives the digit outputs to the 7-segment decoders.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per count tick (1 s at 50 MHz); legal range >= 2.
- MAX_VAL, 59: highest count value (binary, 1..99); the counter wraps between MAX_VAL and 0.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous reset, active-low
- start_stop  in  1  start/pause request, level; rising edge acts; already synchronised to clk externally
- clear  in  1  clear request, level; rising edge acts; already synchronised to clk externally
- up_dn  in  1  count direction: 1 = up, 0 = down; sampled on tick cycles and on clear
- ones  out  4  BCD ones digit, 0..9
- tens  out  4  BCD tens digit, 0..9
- state  out  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE
- tick  out  1  one-cycle pulse on each count update
- wrap  out  1  one-cycle pulse when the count wraps; coincident with tick

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; ones=0, tens=0; tick=0, wrap=0; prescaler=0.
  - Both edge-detect history registers are set to 1, so an input held high through reset release does not produce an edge.
- Edge detect: `ss_edge = start_stop & ~ss_prev` and `clr_edge = clear & ~clr_prev`. The prev registers update every cycle. An edge present in cycle n takes effect at the clk edge ending cycle n, so the new state is visible in cycle n+1.
- FSM transitions:
  - IDLE: ss_edge -> RUN.
  - RUN: ss_edge -> PAUSE.
  - PAUSE: ss_edge -> RUN.
  - Any state: clr_edge -> IDLE.
  - Encoding 11 is unreachable; if entered, the next clk moves to IDLE.
- Simultaneous clr_edge and ss_edge: clear wins; next state is IDLE and start_stop is ignored.
- Clear action:
  - up_dn=1: count loads 00.
  - up_dn=0: count loads MAX_VAL in BCD.
  - Prescaler loads 0; tick and wrap stay 0.
- Prescaler:
  - RUN: counts 0..TICK_DIV-1 and wraps to 0.
  - PAUSE: holds, so a resume continues the partial period.
  - IDLE: forced to 0.
  - Width is `$clog2(TICK_DIV)`.
- Tick: tick=1 for exactly one cycle, registered, in the cycle after the prescaler reaches TICK_DIV-1 while in RUN. The count update is visible in the same cycle as tick.
  - The first tick after IDLE->RUN occurs TICK_DIV cycles after state becomes RUN.
  - Tick period is TICK_DIV cycles.
- Count update on tick, using BCD arithmetic:
  - Up: ones increments; at 9 it goes to 0 and tens increments.
  - Down: ones decrements; at 0 it goes to 9 and tens decrements.
  - Count values never leave 00..MAX_VAL.
- Wrap:
  - Up at MAX_VAL -> 00 with wrap=1.
  - Down at 00 -> MAX_VAL with wrap=1.
  - Counting continues after a wrap; the state stays RUN.
- Direction change mid-run: takes effect on the next tick; no extra tick and no prescaler reset.
- Transition into PAUSE in the cycle the prescaler is at TICK_DIV-1: the tick still fires, since the state at the evaluating edge was RUN.
- Reset mid-operation: immediate return to the reset values, no completion of a pending tick.

Test Plan (TICK_DIV=4, MAX_VAL=12):
- Release reset with start_stop=1 held -> state stays 00, count 00, no tick; drop start_stop, then raise it -> state=01 next cycle.
- IDLE->RUN with up_dn=1, run 13 ticks -> digits 01..12 then 00; wrap=1 only on the 12->00 tick; ticks spaced exactly 4 cycles.
- up_dn=0, pulse clear, then start -> count loads 12; first tick gives 11; at 00 the next tick gives 12 with wrap=1.
- RUN for 2 cycles after a tick, pause for 10 cycles, resume -> next tick 2 cycles after resume; no tick and no count change during PAUSE.
- clear and start_stop rising in the same cycle while in RUN -> state=00, count 00, prescaler 0, no tick.
- Assert rst mid-RUN at count 07 -> all outputs zero immediately (asynchronous); after release, state IDLE and no spurious tick.

Source files
------------

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/clear controller for a two-digit BCD stopwatch counter.
// An internal prescaler issues single-cycle count ticks so everything stays in the clk domain.
module bcd_stopwatch_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int MAX_VAL  = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       up_dn,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [1:0] state,
  output logic       tick,
  output logic       wrap
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_BAD   = 2'b11
  } state_e;

  localparam int             PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]     MAX_ONES   = 4'(MAX_VAL % 10);
  localparam logic [3:0]     MAX_TENS   = 4'(MAX_VAL / 10);

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [3:0]    ones_q;
  logic [3:0]    tens_q;
  logic          tick_q;
  logic          wrap_q;
  logic          ss_prev_q;
  logic          clr_prev_q;

  logic          ss_edge;
  logic          clr_edge;
  logic          presc_done;
  logic [3:0]    ones_d;
  logic [3:0]    tens_d;
  logic          wrap_d;

  assign ss_edge    = start_stop & ~ss_prev_q;
  assign clr_edge   = clear & ~clr_prev_q;
  assign presc_done = (state_q == S_RUN) && (presc_q == PRESC_LAST);

  // One BCD step in the requested direction, wrapping between MAX_VAL and 00.
  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    wrap_d = 1'b0;
    if (up_dn) begin
      if (ones_q == MAX_ONES && tens_q == MAX_TENS) begin
        ones_d = 4'd0;
        tens_d = 4'd0;
        wrap_d = 1'b1;
      end else if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else begin
      if (ones_q == 4'd0 && tens_q == 4'd0) begin
        ones_d = MAX_ONES;
        tens_d = MAX_TENS;
        wrap_d = 1'b1;
      end else if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      // NOTE: history resets high so a button held through reset release is not seen as a press.
      ss_prev_q  <= 1'b1;
      clr_prev_q <= 1'b1;
    end else begin
      ss_prev_q  <= start_stop;
      clr_prev_q <= clear;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;

      if (clr_edge) begin
        state_q <= S_IDLE;
        presc_q <= '0;
        if (up_dn) begin
          ones_q <= 4'd0;
          tens_q <= 4'd0;
        end else begin
          ones_q <= MAX_ONES;
          tens_q <= MAX_TENS;
        end
      end else begin
        unique case (state_q)
          S_IDLE: begin
            presc_q <= '0;
            if (ss_edge) state_q <= S_RUN;
          end
          S_RUN: begin
            // A pause requested on the terminal prescaler cycle still lets this tick land.
            if (presc_done) begin
              presc_q <= '0;
              tick_q  <= 1'b1;
              wrap_q  <= wrap_d;
              ones_q  <= ones_d;
              tens_q  <= tens_d;
            end else begin
              presc_q <= presc_q + PW'(1);
            end
            if (ss_edge) state_q <= S_PAUSE;
          end
          S_PAUSE: begin
            if (ss_edge) state_q <= S_RUN;
          end
          default: begin
            state_q <= S_IDLE;
            presc_q <= '0;
          end
        endcase
      end
    end
  end

  assign ones  = ones_q;
  assign tens  = tens_q;
  assign state = state_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl; expected tick results come from an integer count model
// pushed to a queue as stimulus is applied and popped when the DUT pulses tick.
module tb_bcd_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
  localparam int MAX_VAL  = 12;

  typedef struct {
    logic [3:0] ones;
    logic [3:0] tens;
    logic       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_stop;
  logic       clear;
  logic       up_dn;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [1:0] state;
  logic       tick;
  logic       wrap;

  int   total = 0;
  int   bad   = 0;
  int   cnt   = 0;
  exp_t sb[$];

  bcd_stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .MAX_VAL(MAX_VAL)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_stop(start_stop),
    .clear     (clear),
    .up_dn     (up_dn),
    .ones      (ones),
    .tens      (tens),
    .state     (state),
    .tick      (tick),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model of the counter in plain binary; digits derived by division.
  function automatic void push_tick(input logic up);
    exp_t e;
    e.wrap = 1'b0;
    if (up) begin
      if (cnt == MAX_VAL) begin cnt = 0; e.wrap = 1'b1; end
      else cnt = cnt + 1;
    end else begin
      if (cnt == 0) begin cnt = MAX_VAL; e.wrap = 1'b1; end
      else cnt = cnt - 1;
    end
    e.ones = 4'(cnt % 10);
    e.tens = 4'(cnt / 10);
    sb.push_back(e);
  endfunction

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      check("tick_ones", {4'd0, ones}, {4'd0, e.ones});
      check("tick_tens", {4'd0, tens}, {4'd0, e.tens});
      check("tick_wrap", {7'd0, wrap}, {7'd0, e.wrap});
    end
  endtask

  task automatic wait_tick(input int exp_gap);
    int   n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 4 * TICK_DIV) begin
      step();
      n++;
      if (tick === 1'b1) seen = 1'b1;
      else check("wrap_without_tick", {7'd0, wrap}, 8'd0);
    end
    check("tick_seen", {7'd0, seen}, 8'd1);
    check("tick_gap", 8'(n), 8'(exp_gap));
    pop_check();
  endtask

  initial begin
    rst        = 1'b0;
    start_stop = 1'b1;
    clear      = 1'b0;
    up_dn      = 1'b1;
    repeat (2) step();
    check("rst_state", {6'd0, state}, 8'd0);
    check("rst_ones", {4'd0, ones}, 8'd0);
    check("rst_tens", {4'd0, tens}, 8'd0);
    check("rst_tick", {7'd0, tick}, 8'd0);
    check("rst_wrap", {7'd0, wrap}, 8'd0);

    // start_stop held high across reset release must not start the counter
    rst = 1'b1;
    repeat (3) begin
      step();
      check("held_ss_state", {6'd0, state}, 8'd0);
      check("held_ss_tick", {7'd0, tick}, 8'd0);
    end
    start_stop = 1'b0;
    step();
    check("ss_low_state", {6'd0, state}, 8'd0);
    start_stop = 1'b1;
    step();
    check("start_run", {6'd0, state}, 8'd1);
    start_stop = 1'b0;

    // count up through the wrap
    cnt = 0;
    repeat (13) push_tick(1'b1);
    repeat (13) wait_tick(TICK_DIV);
    check("after_up_state", {6'd0, state}, 8'd1);

    // down counting: clear loads MAX_VAL
    up_dn = 1'b0;
    clear = 1'b1;
    step();
    check("clr_dn_state", {6'd0, state}, 8'd0);
    check("clr_dn_ones", {4'd0, ones}, 8'(MAX_VAL % 10));
    check("clr_dn_tens", {4'd0, tens}, 8'(MAX_VAL / 10));
    check("clr_dn_tick", {7'd0, tick}, 8'd0);
    clear = 1'b0;
    cnt   = MAX_VAL;
    step();
    start_stop = 1'b1;
    step();
    check("start_dn", {6'd0, state}, 8'd1);
    start_stop = 1'b0;
    repeat (13) push_tick(1'b0);
    repeat (13) wait_tick(TICK_DIV);

    // pause two cycles after a tick, hold, then resume the partial period
    step();
    start_stop = 1'b1;
    step();
    check("pause_state", {6'd0, state}, 8'd2);
    start_stop = 1'b0;
    repeat (10) begin
      step();
      check("pause_tick", {7'd0, tick}, 8'd0);
      check("pause_ones", {4'd0, ones}, 8'(MAX_VAL % 10));
      check("pause_tens", {4'd0, tens}, 8'(MAX_VAL / 10));
      check("pause_hold", {6'd0, state}, 8'd2);
    end
    start_stop = 1'b1;
    step();
    check("resume_state", {6'd0, state}, 8'd1);
    start_stop = 1'b0;
    push_tick(1'b0);
    wait_tick(2);

    // pause requested on the terminal prescaler cycle: tick still fires
    repeat (3) step();
    start_stop = 1'b1;
    push_tick(1'b0);
    step();
    check("edge_pause_state", {6'd0, state}, 8'd2);
    check("edge_pause_tick", {7'd0, tick}, 8'd1);
    pop_check();
    start_stop = 1'b0;
    step();
    check("edge_pause_quiet", {7'd0, tick}, 8'd0);
    start_stop = 1'b1;
    step();
    check("edge_resume", {6'd0, state}, 8'd1);
    start_stop = 1'b0;
    push_tick(1'b0);
    wait_tick(TICK_DIV);

    // clear and start_stop rising together: clear wins
    repeat (2) step();
    up_dn      = 1'b1;
    clear      = 1'b1;
    start_stop = 1'b1;
    step();
    check("both_state", {6'd0, state}, 8'd0);
    check("both_ones", {4'd0, ones}, 8'd0);
    check("both_tens", {4'd0, tens}, 8'd0);
    check("both_tick", {7'd0, tick}, 8'd0);
    clear      = 1'b0;
    start_stop = 1'b0;
    cnt        = 0;
    repeat (5) begin
      step();
      check("idle_tick", {7'd0, tick}, 8'd0);
      check("idle_state", {6'd0, state}, 8'd0);
    end
    start_stop = 1'b1;
    step();
    check("restart", {6'd0, state}, 8'd1);
    start_stop = 1'b0;
    repeat (7) push_tick(1'b1);
    repeat (7) wait_tick(TICK_DIV);

    // asynchronous reset mid-run at count 07
    repeat (2) step();
    #2;
    rst = 1'b0;
    #1;
    check("async_state", {6'd0, state}, 8'd0);
    check("async_ones", {4'd0, ones}, 8'd0);
    check("async_tens", {4'd0, tens}, 8'd0);
    check("async_tick", {7'd0, tick}, 8'd0);
    check("async_wrap", {7'd0, wrap}, 8'd0);
    step();
    rst = 1'b1;
    repeat (6) begin
      step();
      check("post_rst_state", {6'd0, state}, 8'd0);
      check("post_rst_tick", {7'd0, tick}, 8'd0);
      check("post_rst_ones", {4'd0, ones}, 8'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
